// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the fetch PC, drives the instruction memory port
// and holds the IF/ID pipeline register handed to decode.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam if_id_t      BUBBLE           = '{instruction: NOP_WORD, pc_plus4: 32'd0, valid: 1'b0};

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] branch_addr;
  logic        redirect;
  if_id_t      if_id_q;
  if_id_t      if_id_next;

  // Byte-offset bits of the branch target are discarded; PC stays word aligned.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];

  assign pc_plus4    = pc_q + 32'd4;
  assign jump_target = {if_id_q.pc_plus4[31:28], jump_index, 2'b00};
  assign branch_addr = {branch_target[31:2], 2'b00};
  assign redirect    = jump | branch_taken;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pc_next    = pc_q;
    if_id_next = if_id_q;

    if (jump) begin
      pc_next = jump_target;
    end else if (branch_taken) begin
      pc_next = branch_addr;
    end else if (!stall && imem_ready) begin
      pc_next = pc_plus4;
    end

    // A redirect or a flush squashes whatever was fetched; a stall holds
    // decode's instruction; a missed fetch hands decode a bubble and retries.
    if (flush || redirect) begin
      if_id_next = BUBBLE;
    end else if (!stall) begin
      if (imem_ready) begin
        if_id_next = '{instruction: imem_rdata, pc_plus4: pc_plus4, valid: 1'b1};
      end else begin
        if_id_next = BUBBLE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC_ALIGNED;
      if_id_q <= BUBBLE;
    end else begin
      pc_q    <= pc_next;
      if_id_q <= if_id_next;
    end
  end

  assign pc                = pc_q;
  assign imem_addr         = pc_q;
  assign imem_req          = ~rst;
  assign if_id_instruction = if_id_q.instruction;
  assign if_id_pc_plus4    = if_id_q.pc_plus4;
  assign if_id_valid       = if_id_q.valid;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000: instruction word inserted as a bubble.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  hazard hold; freezes PC and the IF/ID register.
REQ-006 flush  input  1  kills the IF/ID contents; loads a bubble.
REQ-007 branch_taken  input  1  taken-branch redirect from the decode stage.
REQ-008 branch_target  input  32  branch destination byte address.
REQ-009 jump  input  1  jump redirect from the decode stage.
REQ-010 jump_index  input  26  jump field of the instruction in decode.
REQ-011 imem_req  output  1  instruction memory read request.
REQ-012 imem_addr  output  32  instruction memory byte address (equals pc).
REQ-013 imem_rdata  input  32  instruction memory read data, valid when imem_ready=1.
REQ-014 imem_ready  input  1  read data valid this cycle.
REQ-015 pc  output  32  current fetch PC.
REQ-016 if_id_instruction  output  32  registered instruction to decode.
REQ-017 if_id_pc_plus4  output  32  registered fetch PC + 4 for that instruction.
REQ-018 if_id_valid  output  1  IF/ID holds a real instruction.

Function
REQ-019 imem_addr SHALL equal pc combinationally; imem_req SHALL be 1 whenever rst=0.
REQ-020 A fetch completes in a cycle with imem_req=1 and imem_ready=1; read latency from address to data capture is one edge.
REQ-021 pc[1:0] SHALL always be 2'b00; branch_target[1:0] is ignored and replaced by 2'b00.
REQ-022 Jump target = {if_id_pc_plus4[31:28], jump_index, 2'b00}.
REQ-023 PC update priority per edge: rst > jump > branch_taken > stall > (imem_ready ? pc+4 : hold).
REQ-024 When jump and branch_taken are both 1, the jump target SHALL be used.
REQ-025 A redirect (jump or branch_taken) SHALL override stall and imem_ready=0; on a redirect, IF/ID loads a bubble.
REQ-026 Bubble = if_id_instruction NOP_WORD, if_id_valid 0, if_id_pc_plus4 0.
REQ-027 IF/ID update priority per edge: rst > flush > redirect > stall (hold) > imem_ready ? capture : bubble.
REQ-028 Capture loads if_id_instruction=imem_rdata, if_id_pc_plus4=pc+4, if_id_valid=1.
REQ-029 If flush=1 and stall=1 with no redirect, IF/ID SHALL load a bubble and PC SHALL hold.
REQ-030 If imem_ready=0 with no stall and no redirect, PC SHALL hold and IF/ID SHALL load a bubble; the fetch retries the same address.
REQ-031 pc+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-032 The block SHALL have no combinational path from imem_rdata or imem_ready to any output.

Reset
REQ-033 While rst=1 at an edge: pc=RESET_PC, if_id_instruction=NOP_WORD, if_id_pc_plus4=0, if_id_valid=0; imem_req=0 while rst is high.
REQ-034 rst SHALL override every other input in the same cycle, including during an outstanding fetch or redirect.
REQ-035 The first fetch SHALL use address RESET_PC in the first cycle after rst deasserts.

Verification
REQ-036 Reset, then imem_ready=1 for 4 cycles with rdata=0x1000+addr -> pc 0,4,8,C,10; IF/ID shows (0x1000,4,valid), (0x1004,8,valid), etc.
REQ-037 Fetch at pc=0x20, then stall=1 for 2 cycles -> pc stays 0x20 and IF/ID unchanged; both resume on release.
REQ-038 if_id_pc_plus4=0x40000010, jump=1, jump_index=0x0000100, branch_taken=1, branch_target=0x80 -> pc=0x40000400, IF/ID bubble.
REQ-039 branch_taken=1, target=0x103 with stall=1 and imem_ready=0 -> pc=0x100, if_id_valid=0.
REQ-040 pc=0xFFFFFFFC, imem_ready=1 -> pc=0x0, if_id_pc_plus4=0x0, valid=1; then imem_ready=0 for 3 cycles -> pc holds at 0, 3 bubbles.
REQ-041 rst asserted during a stall and pending redirect -> next edge pc=RESET_PC, IF/ID bubble, imem_req=0.
